// File: rtl/inv_kinematics_calculator_if.sv
// Request/result bundle of the mecanum inverse-kinematics engine: body-velocity command in,
// four wheel-speed setpoints plus status out.
interface inv_kinematics_calculator_if #(
    parameter int N_WIDTH = 17
);
    logic                      INV_KINEMATICS_START_InLow;
    logic signed [N_WIDTH-1:0] INV_KINEMATICS_VX_InBus;
    logic signed [N_WIDTH-1:0] INV_KINEMATICS_VY_InBus;
    logic signed [N_WIDTH-1:0] INV_KINEMATICS_WZ_InBus;
    logic signed [N_WIDTH-1:0] INV_KINEMATICS_W1_OutBus;
    logic signed [N_WIDTH-1:0] INV_KINEMATICS_W2_OutBus;
    logic signed [N_WIDTH-1:0] INV_KINEMATICS_W3_OutBus;
    logic signed [N_WIDTH-1:0] INV_KINEMATICS_W4_OutBus;
    logic                      INV_KINEMATICS_BUSY_Out;
    logic                      INV_KINEMATICS_VALID_Out;
    logic                      INV_KINEMATICS_SAT_Out;

    modport master (
        output INV_KINEMATICS_START_InLow, INV_KINEMATICS_VX_InBus,
               INV_KINEMATICS_VY_InBus, INV_KINEMATICS_WZ_InBus,
        input  INV_KINEMATICS_W1_OutBus, INV_KINEMATICS_W2_OutBus,
               INV_KINEMATICS_W3_OutBus, INV_KINEMATICS_W4_OutBus,
               INV_KINEMATICS_BUSY_Out, INV_KINEMATICS_VALID_Out, INV_KINEMATICS_SAT_Out
    );

    modport slave (
        input  INV_KINEMATICS_START_InLow, INV_KINEMATICS_VX_InBus,
               INV_KINEMATICS_VY_InBus, INV_KINEMATICS_WZ_InBus,
        output INV_KINEMATICS_W1_OutBus, INV_KINEMATICS_W2_OutBus,
               INV_KINEMATICS_W3_OutBus, INV_KINEMATICS_W4_OutBus,
               INV_KINEMATICS_BUSY_Out, INV_KINEMATICS_VALID_Out, INV_KINEMATICS_SAT_Out
    );
endinterface

// File: rtl/inv_kinematics_calculator.sv
// Mecanum inverse kinematics (vx, vy, wz) -> W1..W4 using one shared multiplier over an 8-cycle FSM.
// Define INV_KINEMATICS_SATURATE_EN to clamp wheel speeds and report SAT_Out; otherwise results wrap.
module inv_kinematics_calculator #(
    parameter int N_WIDTH = 17,
    parameter int Q_WIDTH = 8,
    parameter int K_GEOM  = 64,
    parameter int INV_R   = 6400
) (
    input  logic                              INV_KINEMATICS_CLOCK_50,
    input  logic                              INV_KINEMATICS_Reset_InHigh,
    inv_kinematics_calculator_if.slave        bus
);
    localparam int S_W = N_WIDTH + 2;
    localparam int P_W = S_W + N_WIDTH;

    localparam logic signed [N_WIDTH-1:0] C_K     = N_WIDTH'(K_GEOM);
    localparam logic signed [N_WIDTH-1:0] C_INV_R = N_WIDTH'(INV_R);
    localparam logic signed [P_W-1:0]     C_MAX   = P_W'((longint'(1) <<< (N_WIDTH - 1)) - 1);
    localparam logic signed [P_W-1:0]     C_MIN   = -C_MAX - P_W'(1);

    typedef enum logic [2:0] {
        S_IDLE, S_MULK, S_SUM, S_MUL1, S_MUL2, S_MUL3, S_MUL4, S_DONE
    } state_t;

    state_t                     r_state;
    logic signed [N_WIDTH-1:0]  r_vx, r_vy, r_wz;
    logic signed [S_W-1:0]      r_kw;
    logic signed [S_W-1:0]      r_s [4];
    logic signed [N_WIDTH-1:0]  r_t [4];
    logic        [3:0]          r_sat_flags;
    logic signed [N_WIDTH-1:0]  r_w [4];
    logic                       r_busy, r_valid, r_sat;

    logic signed [S_W-1:0]      w_mul_a;
    logic signed [N_WIDTH-1:0]  w_mul_b;
    logic signed [P_W-1:0]      w_product;
    logic signed [P_W-1:0]      w_shifted;

    // Reduce a shifted product to a wheel word; MSB of the result is the clip flag.
    function automatic logic [N_WIDTH:0] f_reduce(input logic signed [P_W-1:0] v);
`ifdef INV_KINEMATICS_SATURATE_EN
        if (v > C_MAX)      return {1'b1, C_MAX[N_WIDTH-1:0]};
        else if (v < C_MIN) return {1'b1, C_MIN[N_WIDTH-1:0]};
        else                return {1'b0, v[N_WIDTH-1:0]};
`else
        return {1'b0, v[N_WIDTH-1:0]};
`endif
    endfunction

    // NOTE: every variable gets a default before the case, so no latch can be inferred.
    always_comb begin
        w_mul_a = r_s[0];
        w_mul_b = C_INV_R;
        case (r_state)
            S_MULK: begin
                w_mul_a = S_W'(r_wz);
                w_mul_b = C_K;
            end
            S_MUL2:  w_mul_a = r_s[1];
            S_MUL3:  w_mul_a = r_s[2];
            S_MUL4:  w_mul_a = r_s[3];
            default: ;
        endcase
    end

    assign w_product = P_W'(w_mul_a) * P_W'(w_mul_b);
    assign w_shifted = w_product >>> Q_WIDTH;

    // NOTE: state uses non-blocking assignments; the small working registers are reset too,
    // since an aborted request must leave nothing behind.
    always_ff @(posedge INV_KINEMATICS_CLOCK_50 or posedge INV_KINEMATICS_Reset_InHigh) begin
        if (INV_KINEMATICS_Reset_InHigh) begin
            r_state     <= S_IDLE;
            r_vx        <= '0;
            r_vy        <= '0;
            r_wz        <= '0;
            r_kw        <= '0;
            r_sat_flags <= '0;
            r_busy      <= 1'b0;
            r_valid     <= 1'b0;
            r_sat       <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                r_s[i] <= '0;
                r_t[i] <= '0;
                r_w[i] <= '0;
            end
        end else begin
            r_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (!bus.INV_KINEMATICS_START_InLow) begin
                        r_vx    <= bus.INV_KINEMATICS_VX_InBus;
                        r_vy    <= bus.INV_KINEMATICS_VY_InBus;
                        r_wz    <= bus.INV_KINEMATICS_WZ_InBus;
                        r_busy  <= 1'b1;
                        r_state <= S_MULK;
                    end
                end
                S_MULK: begin
                    r_kw    <= w_shifted[S_W-1:0];
                    r_state <= S_SUM;
                end
                S_SUM: begin
                    r_s[0]  <= S_W'(r_vx) - S_W'(r_vy) - r_kw;
                    r_s[1]  <= S_W'(r_vx) + S_W'(r_vy) + r_kw;
                    r_s[2]  <= S_W'(r_vx) + S_W'(r_vy) - r_kw;
                    r_s[3]  <= S_W'(r_vx) - S_W'(r_vy) + r_kw;
                    r_state <= S_MUL1;
                end
                S_MUL1: begin
                    {r_sat_flags[0], r_t[0]} <= f_reduce(w_shifted);
                    r_state <= S_MUL2;
                end
                S_MUL2: begin
                    {r_sat_flags[1], r_t[1]} <= f_reduce(w_shifted);
                    r_state <= S_MUL3;
                end
                S_MUL3: begin
                    {r_sat_flags[2], r_t[2]} <= f_reduce(w_shifted);
                    r_state <= S_MUL4;
                end
                S_MUL4: begin
                    {r_sat_flags[3], r_t[3]} <= f_reduce(w_shifted);
                    r_state <= S_DONE;
                end
                S_DONE: begin
                    for (int i = 0; i < 4; i++) r_w[i] <= r_t[i];
                    r_sat   <= |r_sat_flags;
                    r_valid <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.INV_KINEMATICS_W1_OutBus = r_w[0];
    assign bus.INV_KINEMATICS_W2_OutBus = r_w[1];
    assign bus.INV_KINEMATICS_W3_OutBus = r_w[2];
    assign bus.INV_KINEMATICS_W4_OutBus = r_w[3];
    assign bus.INV_KINEMATICS_BUSY_Out  = r_busy;
    assign bus.INV_KINEMATICS_VALID_Out = r_valid;
    assign bus.INV_KINEMATICS_SAT_Out   = r_sat;
endmodule

// File: tb/tb_inv_kinematics_calculator.sv
// Self-checking bench for inv_kinematics_calculator: directed cases plus random requests
// compared against an arithmetic model of the wheel equations (K_GEOM=64, INV_R=512).
module tb_inv_kinematics_calculator;
    localparam int N   = 17;
    localparam int Q   = 8;
    localparam int K   = 64;
    localparam int R   = 512;

    logic clk;
    logic rst;
    int   n_checks = 0;
    int   n_fail   = 0;

    longint exp_w [4];
    bit     exp_sat;
    longint last_w [4];
    bit     last_sat;

    inv_kinematics_calculator_if #(.N_WIDTH(N)) bus ();

    inv_kinematics_calculator #(
        .N_WIDTH (N),
        .Q_WIDTH (Q),
        .K_GEOM  (K),
        .INV_R   (R)
    ) dut (
        .INV_KINEMATICS_CLOCK_50     (clk),
        .INV_KINEMATICS_Reset_InHigh (rst),
        .bus                         (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic longint wout(input int i);
        case (i)
            0:       return longint'(bus.INV_KINEMATICS_W1_OutBus);
            1:       return longint'(bus.INV_KINEMATICS_W2_OutBus);
            2:       return longint'(bus.INV_KINEMATICS_W3_OutBus);
            default: return longint'(bus.INV_KINEMATICS_W4_OutBus);
        endcase
    endfunction

    // Reference: plain integer arithmetic straight from the wheel equations.
    task automatic model(input longint vx, input longint vy, input longint wz);
        longint kw, s, t, lim_hi, lim_lo;
        lim_hi  = (longint'(1) <<< (N - 1)) - 1;
        lim_lo  = -(longint'(1) <<< (N - 1));
        kw      = (longint'(K) * wz) >>> Q;
        exp_sat = 1'b0;
        for (int i = 0; i < 4; i++) begin
            case (i)
                0:       s = vx - vy - kw;
                1:       s = vx + vy + kw;
                2:       s = vx + vy - kw;
                default: s = vx - vy + kw;
            endcase
            t = (longint'(R) * s) >>> Q;
`ifdef INV_KINEMATICS_SATURATE_EN
            if (t > lim_hi)      begin t = lim_hi; exp_sat = 1'b1; end
            else if (t < lim_lo) begin t = lim_lo; exp_sat = 1'b1; end
`else
            t = t & ((longint'(1) <<< N) - 1);
            if (t > lim_hi) t = t - (longint'(1) <<< N);
`endif
            exp_w[i] = t;
        end
    endtask

    task automatic drive_inputs(input logic signed [N-1:0] vx, input logic signed [N-1:0] vy,
                                input logic signed [N-1:0] wz);
        bus.INV_KINEMATICS_VX_InBus = vx;
        bus.INV_KINEMATICS_VY_InBus = vy;
        bus.INV_KINEMATICS_WZ_InBus = wz;
    endtask

    task automatic check_result(input string tag);
        for (int i = 0; i < 4; i++) check($sformatf("%s_w%0d", tag, i + 1), wout(i), exp_w[i]);
        check({tag, "_sat"}, longint'(bus.INV_KINEMATICS_SAT_Out), longint'(exp_sat));
        last_w   = exp_w;
        last_sat = exp_sat;
    endtask

    // One request with full timing checks; poke re-asserts START at edge 3 while busy.
    task automatic do_req(input string tag, input logic signed [N-1:0] vx,
                          input logic signed [N-1:0] vy, input logic signed [N-1:0] wz,
                          input bit poke);
        int early_valid;
        early_valid = 0;
        model(longint'(vx), longint'(vy), longint'(wz));
        @(negedge clk);
        drive_inputs(vx, vy, wz);
        bus.INV_KINEMATICS_START_InLow = 1'b0;
        @(posedge clk); #1;
        check({tag, "_busy_e0"}, longint'(bus.INV_KINEMATICS_BUSY_Out), 1);
        @(negedge clk);
        bus.INV_KINEMATICS_START_InLow = 1'b1;
        drive_inputs(N'($urandom), N'($urandom), N'($urandom));
        for (int k = 1; k <= 6; k++) begin
            if (poke && k == 3) begin
                @(negedge clk);
                bus.INV_KINEMATICS_START_InLow = 1'b0;
            end
            @(posedge clk); #1;
            if (bus.INV_KINEMATICS_VALID_Out) early_valid++;
            if (poke && k == 3) begin
                @(negedge clk);
                bus.INV_KINEMATICS_START_InLow = 1'b1;
            end
        end
        check({tag, "_early_valid"}, early_valid, 0);
        check({tag, "_hold_w1"}, wout(0), last_w[0]);
        @(posedge clk); #1;
        check({tag, "_valid_e7"}, longint'(bus.INV_KINEMATICS_VALID_Out), 1);
        check({tag, "_busy_e7"}, longint'(bus.INV_KINEMATICS_BUSY_Out), 0);
        check_result(tag);
        @(posedge clk); #1;
        check({tag, "_valid_e8"}, longint'(bus.INV_KINEMATICS_VALID_Out), 0);
        check({tag, "_busy_e8"}, longint'(bus.INV_KINEMATICS_BUSY_Out), 0);
    endtask

    initial begin
        int vcnt;
        for (int i = 0; i < 4; i++) last_w[i] = 0;
        last_sat = 1'b0;
        rst = 1'b1;
        bus.INV_KINEMATICS_START_InLow = 1'b1;
        drive_inputs('0, '0, '0);
        repeat (3) @(posedge clk);
        #1;
        check("rst_w1", wout(0), 0);
        check("rst_w4", wout(3), 0);
        check("rst_busy", longint'(bus.INV_KINEMATICS_BUSY_Out), 0);
        check("rst_valid", longint'(bus.INV_KINEMATICS_VALID_Out), 0);
        check("rst_sat", longint'(bus.INV_KINEMATICS_SAT_Out), 0);
        @(negedge clk);
        rst = 1'b0;

        do_req("fwd", 17'sd256, 17'sd0, 17'sd0, 1'b0);
        check("fwd_const_w1", wout(0), 512);
        do_req("strafe", 17'sd0, 17'sd256, 17'sd0, 1'b0);
        check("strafe_const_w1", wout(0), -512);
        check("strafe_const_w2", wout(1), 512);
        do_req("rot", 17'sd0, 17'sd0, 17'sd256, 1'b0);
        check("rot_const_w1", wout(0), -128);
        check("rot_const_w2", wout(1), 128);
        do_req("ovf", 17'sd51200, -17'sd51200, 17'sd0, 1'b0);
`ifdef INV_KINEMATICS_SATURATE_EN
        check("ovf_const_w1", wout(0), 65535);
        check("ovf_const_sat", longint'(bus.INV_KINEMATICS_SAT_Out), 1);
`else
        check("ovf_const_w1", wout(0), -57344);
        check("ovf_const_sat", longint'(bus.INV_KINEMATICS_SAT_Out), 0);
`endif
        check("ovf_const_w2", wout(1), 0);

        do_req("poke", 17'sd300, -17'sd100, 17'sd512, 1'b1);
        vcnt = 0;
        repeat (12) begin
            @(posedge clk); #1;
            if (bus.INV_KINEMATICS_VALID_Out) vcnt++;
        end
        check("poke_no_extra_valid", vcnt, 0);

        // START held low: captures at edge 0 and edge 8, results at edges 7 and 15.
        @(negedge clk);
        drive_inputs(17'sd1000, 17'sd200, -17'sd300);
        bus.INV_KINEMATICS_START_InLow = 1'b0;
        @(posedge clk);
        @(negedge clk);
        drive_inputs(-17'sd700, 17'sd50, 17'sd1024);
        repeat (7) @(posedge clk);
        #1;
        check("held_valid1", longint'(bus.INV_KINEMATICS_VALID_Out), 1);
        model(1000, 200, -300);
        check_result("held1");
        @(posedge clk); #1;
        check("held_busy_e8", longint'(bus.INV_KINEMATICS_BUSY_Out), 1);
        @(negedge clk);
        bus.INV_KINEMATICS_START_InLow = 1'b1;
        drive_inputs('0, '0, '0);
        repeat (7) @(posedge clk);
        #1;
        check("held_valid2", longint'(bus.INV_KINEMATICS_VALID_Out), 1);
        model(-700, 50, 1024);
        check_result("held2");

        // Reset mid-request at edge 4.
        @(negedge clk);
        drive_inputs(17'sd4000, 17'sd1000, 17'sd100);
        bus.INV_KINEMATICS_START_InLow = 1'b0;
        @(posedge clk);
        @(negedge clk);
        bus.INV_KINEMATICS_START_InLow = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        for (int i = 0; i < 4; i++) check($sformatf("midrst_w%0d", i + 1), wout(i), 0);
        check("midrst_busy", longint'(bus.INV_KINEMATICS_BUSY_Out), 0);
        check("midrst_sat", longint'(bus.INV_KINEMATICS_SAT_Out), 0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) last_w[i] = 0;
        vcnt = 0;
        repeat (10) begin
            @(posedge clk); #1;
            if (bus.INV_KINEMATICS_VALID_Out) vcnt++;
        end
        check("midrst_no_valid", vcnt, 0);
        do_req("after_rst", 17'sd256, 17'sd0, 17'sd0, 1'b0);

        for (int n = 0; n < 20; n++) begin
            do_req($sformatf("rand%0d", n), N'($urandom), N'($urandom), N'($urandom), 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/inv_kinematics_calculator.md
# inv_kinematics_calculator

Inverse-kinematics engine for the four-wheel mecanum base, the counterpart of the odometry calculator: it takes commanded body velocities (vx, vy, wz) in signed fixed point and produces the four wheel angular-speed setpoints W1..W4 in the same format the odometry path consumes. It sits between the trajectory/command layer and the per-wheel motor controllers. A single shared multiplier is time-multiplexed by a small FSM, so each request takes a fixed, multi-cycle latency.

## Interface
- N_WIDTH, 17: signed word width, two's complement.
- Q_WIDTH, 8: fractional bits (Q8.8 for the default width).
- K_GEOM, 64: (lx+ly) in Q format, default 0.25 m.
- INV_R, 6400: 1/wheel radius in Q format, default 25.0 m⁻¹.

Ports:
- INV_KINEMATICS_CLOCK_50  in  1  system clock.
- INV_KINEMATICS_Reset_InHigh  in  1  asynchronous reset, active high.
- INV_KINEMATICS_START_InLow  in  1  request strobe, active low; sampled only in IDLE.
- INV_KINEMATICS_VX_InBus  in  N_WIDTH  body x velocity, m/s.
- INV_KINEMATICS_VY_InBus  in  N_WIDTH  body y velocity, m/s.
- INV_KINEMATICS_WZ_InBus  in  N_WIDTH  body yaw rate, rad/s.
- INV_KINEMATICS_W1_OutBus..W4_OutBus  out  N_WIDTH each  wheel speeds, rad/s.
- INV_KINEMATICS_BUSY_Out  out  1  high while FSM is not in IDLE.
- INV_KINEMATICS_VALID_Out  out  1  one-cycle pulse when W1..W4 update.
- INV_KINEMATICS_SAT_Out  out  1  high for the result set where any wheel clipped.

## Operation
- Equations: kw = K_GEOM·wz.
  - W1 = INV_R·(vx − vy − kw)
  - W2 = INV_R·(vx + vy + kw)
  - W3 = INV_R·(vx + vy − kw)
  - W4 = INV_R·(vx − vy + kw)
- FSM states: IDLE → MULK → SUM → MUL1 → MUL2 → MUL3 → MUL4 → DONE → IDLE. Every state except IDLE lasts exactly one cycle.
- IDLE: on an edge with START_InLow=0, latch VX/VY/WZ into internal registers and go to MULK. Otherwise stay in IDLE.
- MULK: kw = (K_GEOM·wz) >>> Q_WIDTH, kept at N_WIDTH+2 bits.
- SUM: compute four sums s1..s4 at N_WIDTH+2 bits. The sums themselves never overflow.
- MULn: temp_n = (INV_R·s_n) >>> Q_WIDTH (arithmetic shift, truncation toward −∞), then reduce to N_WIDTH bits according to the Configuration section.
- DONE: copy temp1..4 to W1..W4 simultaneously, update SAT_Out, pulse VALID_Out, return to IDLE.
- Outputs hold their values until the next DONE; they never show a partially updated set.
- START_InLow is ignored while BUSY. A start that arrives while busy is dropped, not queued.
- If START_InLow is held low continuously, a new request is captured every 8 cycles.
- Inputs may change freely after the capture edge.
- Reset (any time, including mid-computation): state=IDLE; W1..W4=0; BUSY=0; VALID=0; SAT=0; internal registers cleared. No VALID pulse follows the aborted request.

## Timing
- Edge 0: capture. Edges 1–6: MULK, SUM, MUL1–MUL4. Edge 7: DONE.
- W1..W4, SAT_Out and VALID_Out change at edge 7.
- VALID_Out is high for exactly one cycle (edge 7 to edge 8).
- BUSY_Out is high from edge 0 through edge 7 (7 cycles).
- The earliest next capture is at edge 8.
- Throughput: one result every 8 cycles.

## Configuration
- INV_KINEMATICS_SATURATE_EN defined:
  - each temp_n is clamped to [−2^(N_WIDTH−1), 2^(N_WIDTH−1)−1];
  - SAT_Out reflects whether any wheel clamped on that request.
- Not defined:
  - temp_n keeps its low N_WIDTH bits (two's-complement wrap);
  - SAT_Out is tied to 0.

## Test plan
All scenarios use K_GEOM=64 (0.25) and INV_R=512 (2.0).
- Pure forward: vx=256, vy=0, wz=0, START low one cycle -> after 7 cycles W1..W4=512, VALID pulses once, SAT=0.
- Pure strafe: vx=0, vy=256 -> W1=−512 (0x1FE00), W2=512, W3=512, W4=−512 (0x1FE00).
- Pure rotation: wz=256 -> kw=64; W1=−128, W2=128, W3=−128, W4=128.
- Overflow: vx=51200, vy=−51200, wz=0:
  - with SATURATE_EN -> W1=W4=65535, W2=W3=0, SAT=1;
  - without -> W1=W4=−57344, SAT=0.
- START_InLow pulsed again at edge 3 of a busy request -> ignored; exactly one VALID pulse, at edge 7; BUSY low at edge 8.
- Reset asserted at edge 4 -> all outputs 0, BUSY=0, no VALID pulse; a fresh START after reset completes normally in 7 cycles.
